// File: rtl/bch_pkg.sv
// bch_pkg: shared states and constants for the BCH decoder control path.
package bch_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SYN, S_BER, S_CHI, S_OUT} state_e;
    localparam logic [9:0] N63 = 10'd63;
    localparam logic [9:0] N255 = 10'd255;
    localparam logic [9:0] N1023 = 10'd1023;
    localparam logic [9:0] OUT_FAIL = 10'h3FF;
    localparam int LLR_PER_BEAT = 8;
    function automatic logic [9:0] code_to_n(input logic [1:0] code);
        return code == 2'd1 ? N63 : code == 2'd2 ? N255 : N1023;
    endfunction
endpackage

// File: rtl/bch_stage_hs.sv
// bch_stage_hs: start pulse, done qualification and watchdog for whichever engine stage is armed.
module bch_stage_hs #(
    parameter int TIMEOUT = 2047
) (
    input  logic clk,
    input  logic rst,
    input  logic arm_i,
    input  logic done_i,
    output logic start_o,
    output logic done_o,
    output logic tmo_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic          active_q;
    logic          start_q;
    logic [CW-1:0] cnt_q;
    assign start_o = start_q;
    // a done coinciding with the start pulse belongs to a previous job
    assign done_o = active_q && !start_q && done_i;
    assign tmo_o = active_q && !start_q && !done_i && cnt_q == CW'(TIMEOUT);
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            start_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            start_q  <= arm_i;
            active_q <= arm_i || (active_q && !done_o && !tmo_o);
            cnt_q    <= arm_i ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/bch_dec_ctrl.sv
// bch_dec_ctrl: sequences codeword load, syndrome/BER/Chien stages and error-location readout.
module bch_dec_ctrl
    import bch_pkg::state_e, bch_pkg::S_IDLE, bch_pkg::S_LOAD, bch_pkg::S_SYN,
           bch_pkg::S_BER, bch_pkg::S_CHI, bch_pkg::S_OUT, bch_pkg::LLR_PER_BEAT;
#(
    parameter int         STAGE_TIMEOUT = 2047,
    parameter logic [9:0] OUT_FAIL      = bch_pkg::OUT_FAIL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set,
    input  logic       mode,
    input  logic [1:0] code,
    output logic       ready,
    output logic       load_we,
    output logic [9:0] load_addr,
    output logic [9:0] len,
    output logic       syn_start,
    output logic       ber_start,
    output logic       chi_start,
    input  logic       syn_done,
    input  logic       ber_done,
    input  logic       chi_done,
    input  logic       ber_fail,
    input  logic [3:0] chi_cnt,
    output logic       cand_sel,
    output logic [3:0] loc_idx,
    input  logic [9:0] loc_data,
    output logic       finish,
    output logic [9:0] odata,
    output logic       dec_fail
);
    state_e     state_q, state_d;
    logic [9:0] load_addr_q, load_addr_d, len_q, len_d, odata_q, odata_d;
    logic [3:0] c0_q, c0_d, k_q, k_d, idx_q, idx_d, nbeat;
    logic       mode_q, mode_d, cand_sel_q, cand_sel_d, fail_q, fail_d;
    logic       finish_q, finish_d, dec_fail_q, dec_fail_d;
    logic       hs_arm, hs_done_in, hs_start, hs_done, hs_tmo;
    bch_stage_hs #(.TIMEOUT(STAGE_TIMEOUT)) u_hs (
        .clk(clk), .rst(rst), .arm_i(hs_arm), .done_i(hs_done_in),
        .start_o(hs_start), .done_o(hs_done), .tmo_o(hs_tmo)
    );
    assign hs_arm = state_d != state_q && (state_d == S_SYN || state_d == S_BER || state_d == S_CHI);
    assign hs_done_in = state_q == S_SYN ? syn_done : state_q == S_BER ? ber_done :
                        state_q == S_CHI ? chi_done : 1'b0;
    assign syn_start = hs_start && state_q == S_SYN;
    assign ber_start = hs_start && state_q == S_BER;
    assign chi_start = hs_start && state_q == S_CHI;
    assign ready = state_q == S_LOAD;
    assign load_we = ready;
    assign load_addr = load_addr_q;
    assign len = len_q;
    assign cand_sel = cand_sel_q;
    assign loc_idx = idx_q;
    assign finish = finish_q;
    assign odata = odata_q;
    assign dec_fail = dec_fail_q;
    assign nbeat = (fail_q || k_q == 4'd0) ? 4'd1 : k_q;
    always_comb begin
        state_d = state_q;
        load_addr_d = load_addr_q;
        len_d = len_q;
        mode_d = mode_q;
        cand_sel_d = cand_sel_q;
        c0_d = c0_q;
        k_d = k_q;
        fail_d = fail_q;
        idx_d = '0;
        finish_d = 1'b0;
        dec_fail_d = 1'b0;
        odata_d = odata_q;
        case (state_q)
            S_IDLE: if (set) begin
                len_d = bch_pkg::code_to_n(code);
                mode_d = mode;
                load_addr_d = len_d;
                cand_sel_d = 1'b0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                load_addr_d = load_addr_q - 10'(LLR_PER_BEAT);
                state_d = load_addr_q == 10'd7 ? S_SYN : S_LOAD;
            end
            S_SYN: if (hs_tmo) begin
                state_d = S_OUT;
                fail_d = 1'b1;
            end else if (hs_done) state_d = S_BER;
            S_BER: if (hs_tmo || (hs_done && ber_fail && !cand_sel_q)) begin
                state_d = S_OUT;
                fail_d = 1'b1;
            end else if (hs_done && ber_fail) begin
                // a failed second pass falls back to the first candidate
                state_d = S_OUT;
                cand_sel_d = 1'b0;
                k_d = c0_q;
                fail_d = 1'b0;
            end else if (hs_done) state_d = S_CHI;
            S_CHI: if (hs_tmo) begin
                state_d = S_OUT;
                fail_d = 1'b1;
            end else if (hs_done && !cand_sel_q) begin
                c0_d = chi_cnt;
                cand_sel_d = mode_q;
                k_d = chi_cnt;
                fail_d = 1'b0;
                state_d = mode_q ? S_BER : S_OUT;
            end else if (hs_done) begin
                state_d = S_OUT;
                fail_d = 1'b0;
                cand_sel_d = chi_cnt < c0_q;
                k_d = chi_cnt < c0_q ? chi_cnt : c0_q;
            end
            S_OUT: if (idx_q == nbeat) state_d = S_IDLE;
            else begin
                finish_d = 1'b1;
                dec_fail_d = fail_q;
                odata_d = (fail_q || k_q == 4'd0) ? OUT_FAIL : loc_data;
                idx_d = idx_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            load_addr_q <= '0;
            len_q       <= '0;
            mode_q      <= 1'b0;
            cand_sel_q  <= 1'b0;
            c0_q        <= '0;
            k_q         <= '0;
            fail_q      <= 1'b0;
            idx_q       <= '0;
            finish_q    <= 1'b0;
            dec_fail_q  <= 1'b0;
            odata_q     <= '0;
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            cand_sel_q  <= cand_sel_d;
            c0_q        <= c0_d;
            k_q         <= k_d;
            fail_q      <= fail_d;
            idx_q       <= idx_d;
            finish_q    <= finish_d;
            dec_fail_q  <= dec_fail_d;
            odata_q     <= odata_d;
        end
    end
endmodule

// File: tb/tb_bch_dec_ctrl.sv
// tb_bch_dec_ctrl: directed scenarios for the BCH decoder sequencer with a modelled location buffer.
module tb_bch_dec_ctrl;
    logic       clk = 1'b0, rst = 1'b0, set = 1'b0, mode = 1'b0;
    logic [1:0] code = 2'd0;
    logic       ready, load_we, syn_start, ber_start, chi_start, finish, dec_fail, cand_sel;
    logic [9:0] load_addr, len, odata, loc_data;
    logic       syn_done = 1'b0, ber_done = 1'b0, chi_done = 1'b0, ber_fail = 1'b0;
    logic [3:0] chi_cnt = 4'd0, loc_idx;
    logic [9:0] locbuf [2][16];
    int         tests_run = 0, fails = 0, chi_starts = 0;

    bch_dec_ctrl dut (
        .clk(clk), .rst(rst), .set(set), .mode(mode), .code(code), .ready(ready),
        .load_we(load_we), .load_addr(load_addr), .len(len), .syn_start(syn_start),
        .ber_start(ber_start), .chi_start(chi_start), .syn_done(syn_done), .ber_done(ber_done),
        .chi_done(chi_done), .ber_fail(ber_fail), .chi_cnt(chi_cnt), .cand_sel(cand_sel),
        .loc_idx(loc_idx), .loc_data(loc_data), .finish(finish), .odata(odata), .dec_fail(dec_fail)
    );

    always #5 clk = ~clk;
    assign loc_data = locbuf[cand_sel][loc_idx];
    always @(posedge clk) if (chi_start) chi_starts <= chi_starts + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int s);
        return s == 0 ? syn_start : s == 1 ? ber_start : s == 2 ? chi_start : finish;
    endfunction

    task automatic do_load(input logic [1:0] c, input logic m, input logic hold,
                           output int beats, output int first, output int last, output logic seq_ok);
        code = c; mode = m; set = 1'b1;
        step();
        if (!hold) set = 1'b0;
        beats = 0; first = -1; last = -1; seq_ok = 1'b1;
        while (ready && beats < 200) begin
            if (beats == 0) first = int'(load_addr);
            else if (int'(load_addr) != last - 8) seq_ok = 1'b0;
            if (load_we !== ready) seq_ok = 1'b0;
            last = int'(load_addr); beats++;
            step();
        end
        set = 1'b0;
    endtask

    task automatic stage(input int s, input int dly, input logic bf, input logic [3:0] cnt, output int lat);
        lat = 0;
        while (!sig(s) && lat < 3000) begin step(); lat++; end
        if (!sig(s)) lat = -1;
        else begin
            repeat (dly) step();
            if (s == 0) syn_done = 1'b1;
            else if (s == 1) begin ber_done = 1'b1; ber_fail = bf; end
            else begin chi_done = 1'b1; chi_cnt = cnt; end
            step();
            syn_done = 1'b0; ber_done = 1'b0; chi_done = 1'b0; ber_fail = 1'b0; chi_cnt = 4'd0;
        end
    endtask

    task automatic collect(input int budget, output int lead, output int nb, output logic [9:0] d0,
                           output logic [9:0] d1, output logic df, output logic cs);
        lead = 0; nb = 0; d0 = '0; d1 = '0; df = 1'b0; cs = 1'b0;
        while (!finish && lead < budget) begin step(); lead++; end
        while (finish && nb < 20) begin
            if (nb == 0) begin d0 = odata; cs = cand_sel; end
            if (nb == 1) d1 = odata;
            df = df | dec_fail;
            step(); nb++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
        tests_run++; if ({ready, load_we, syn_start, ber_start, chi_start, finish, dec_fail, cand_sel} !== 8'd0) begin fails++; $display("FAIL reset_flags got=%b exp=0", {ready, load_we, syn_start, ber_start, chi_start, finish, dec_fail, cand_sel}); end
        tests_run++; if ({odata, load_addr} !== 20'd0) begin fails++; $display("FAIL reset_data odata=%h load_addr=%0d exp 0/0", odata, load_addr); end
    endtask

    task automatic test_hard63();
        int beats, first, last, lat, lead, nb; logic ok, df, cs; logic [9:0] d0, d1;
        locbuf[0][0] = 10'd5; locbuf[0][1] = 10'd40;
        do_load(2'd1, 1'b0, 1'b0, beats, first, last, ok);
        tests_run++; if (beats != 8 || first != 63 || last != 7 || !ok) begin fails++; $display("FAIL h63_load beats=%0d first=%0d last=%0d seq=%b exp 8/63/7/1", beats, first, last, ok); end
        tests_run++; if (len !== 10'd63) begin fails++; $display("FAIL h63_len got=%0d exp=63", len); end
        stage(0, 3, 1'b0, 4'd0, lat);
        tests_run++; if (lat != 0) begin fails++; $display("FAIL h63_syn_lat got=%0d exp=0", lat); end
        stage(1, 2, 1'b0, 4'd0, lat);
        tests_run++; if (lat != 0) begin fails++; $display("FAIL h63_ber_lat got=%0d exp=0", lat); end
        stage(2, 2, 1'b0, 4'd2, lat);
        tests_run++; if (lat != 0) begin fails++; $display("FAIL h63_chi_lat got=%0d exp=0", lat); end
        collect(50, lead, nb, d0, d1, df, cs);
        tests_run++; if (lead != 1 || nb != 2) begin fails++; $display("FAIL h63_out_timing lead=%0d beats=%0d exp 1/2", lead, nb); end
        tests_run++; if (d0 !== 10'd5 || d1 !== 10'd40 || df !== 1'b0) begin fails++; $display("FAIL h63_out_data d0=%0d d1=%0d df=%b exp 5/40/0", d0, d1, df); end
    endtask

    task automatic test_back_to_back();
        int beats, first, last, lat, lead, nb; logic ok, df, cs; logic [9:0] d0, d1;
        do_load(2'd1, 1'b0, 1'b0, beats, first, last, ok);
        tests_run++; if (beats != 8 || first != 63) begin fails++; $display("FAIL b2b_accept beats=%0d first=%0d exp 8/63", beats, first); end
        stage(0, 2, 1'b0, 4'd0, lat); stage(1, 2, 1'b0, 4'd0, lat); stage(2, 2, 1'b0, 4'd1, lat);
        collect(50, lead, nb, d0, d1, df, cs);
        tests_run++; if (nb != 1 || d0 !== 10'd5) begin fails++; $display("FAIL b2b_out beats=%0d d0=%0d exp 1/5", nb, d0); end
    endtask

    task automatic test_code0_zero();
        int beats, first, last, lat, lead, nb; logic ok, df, cs; logic [9:0] d0, d1;
        do_load(2'd0, 1'b0, 1'b0, beats, first, last, ok);
        tests_run++; if (beats != 128 || first != 1023 || last != 7 || !ok) begin fails++; $display("FAIL c0_load beats=%0d first=%0d last=%0d seq=%b exp 128/1023/7/1", beats, first, last, ok); end
        syn_done = 1'b1; step(); syn_done = 1'b0;
        tests_run++; if (ber_start !== 1'b0) begin fails++; $display("FAIL c0_early_done ber_start=%b exp=0", ber_start); end
        step(); syn_done = 1'b1; step(); syn_done = 1'b0;
        stage(1, 2, 1'b0, 4'd0, lat);
        tests_run++; if (lat != 0) begin fails++; $display("FAIL c0_ber_lat got=%0d exp=0", lat); end
        stage(2, 2, 1'b0, 4'd0, lat);
        collect(50, lead, nb, d0, d1, df, cs);
        tests_run++; if (lead != 1 || nb != 1 || d0 !== 10'h3FF || df !== 1'b0) begin fails++; $display("FAIL c0_zero lead=%0d beats=%0d d0=%h df=%b exp 1/1/3ff/0", lead, nb, d0, df); end
    endtask

    task automatic test_soft();
        int beats, first, last, lat, lead, nb; logic ok, df, cs; logic [9:0] d0, d1;
        locbuf[0][0] = 10'd11; locbuf[0][1] = 10'd22; locbuf[0][2] = 10'd33; locbuf[1][0] = 10'd77; locbuf[1][1] = 10'd88;
        do_load(2'd2, 1'b1, 1'b0, beats, first, last, ok);
        tests_run++; if (beats != 32 || first != 255 || last != 7) begin fails++; $display("FAIL soft_load beats=%0d first=%0d last=%0d exp 32/255/7", beats, first, last); end
        stage(0, 2, 1'b0, 4'd0, lat); stage(1, 2, 1'b0, 4'd0, lat); stage(2, 2, 1'b0, 4'd3, lat);
        tests_run++; if (ber_start !== 1'b1 || cand_sel !== 1'b1) begin fails++; $display("FAIL soft_pass1 ber_start=%b cand_sel=%b exp 1/1", ber_start, cand_sel); end
        stage(1, 2, 1'b0, 4'd0, lat); stage(2, 2, 1'b0, 4'd1, lat);
        collect(50, lead, nb, d0, d1, df, cs);
        tests_run++; if (lead != 1 || nb != 1 || cs !== 1'b1 || d0 !== 10'd77) begin fails++; $display("FAIL soft_pick1 lead=%0d beats=%0d sel=%b d0=%0d exp 1/1/1/77", lead, nb, cs, d0); end
        do_load(2'd2, 1'b1, 1'b0, beats, first, last, ok);
        stage(0, 2, 1'b0, 4'd0, lat); stage(1, 2, 1'b0, 4'd0, lat); stage(2, 2, 1'b0, 4'd2, lat);
        stage(1, 2, 1'b0, 4'd0, lat); stage(2, 2, 1'b0, 4'd2, lat);
        collect(50, lead, nb, d0, d1, df, cs);
        tests_run++; if (nb != 2 || cs !== 1'b0 || d0 !== 10'd11 || d1 !== 10'd22) begin fails++; $display("FAIL soft_tie beats=%0d sel=%b d0=%0d d1=%0d exp 2/0/11/22", nb, cs, d0, d1); end
        do_load(2'd2, 1'b1, 1'b0, beats, first, last, ok);
        stage(0, 2, 1'b0, 4'd0, lat); stage(1, 2, 1'b0, 4'd0, lat); stage(2, 2, 1'b0, 4'd3, lat);
        stage(1, 2, 1'b1, 4'd0, lat);
        collect(50, lead, nb, d0, d1, df, cs);
        tests_run++; if (lead != 1 || nb != 3 || cs !== 1'b0 || d0 !== 10'd11 || df !== 1'b0) begin fails++; $display("FAIL soft_p1fail lead=%0d beats=%0d sel=%b d0=%0d df=%b exp 1/3/0/11/0", lead, nb, cs, d0, df); end
    endtask

    task automatic test_ber_fail();
        int beats, first, last, lat, lead, nb, c0; logic ok, df, cs; logic [9:0] d0, d1;
        do_load(2'd1, 1'b0, 1'b0, beats, first, last, ok);
        c0 = chi_starts;
        stage(0, 2, 1'b0, 4'd0, lat); stage(1, 3, 1'b1, 4'd0, lat);
        collect(50, lead, nb, d0, d1, df, cs);
        tests_run++; if (lead != 1 || nb != 1 || d0 !== 10'h3FF || df !== 1'b1) begin fails++; $display("FAIL berfail_out lead=%0d beats=%0d d0=%h df=%b exp 1/1/3ff/1", lead, nb, d0, df); end
        tests_run++; if (chi_starts != c0) begin fails++; $display("FAIL berfail_no_chi chi_starts=%0d exp=%0d", chi_starts, c0); end
    endtask

    task automatic test_timeout();
        int beats, first, last, lat, lead, nb, c0; logic ok, df, cs, busy; logic [9:0] d0, d1;
        do_load(2'd1, 1'b0, 1'b0, beats, first, last, ok);
        stage(0, 2, 1'b0, 4'd0, lat);
        tests_run++; if (ber_start !== 1'b1) begin fails++; $display("FAIL tmo_ber_start got=%b exp=1", ber_start); end
        collect(5000, lead, nb, d0, d1, df, cs);
        tests_run++; if (lead != 2047 + 2 || nb != 1 || d0 !== 10'h3FF || df !== 1'b1) begin fails++; $display("FAIL tmo_abort lead=%0d beats=%0d d0=%h df=%b exp 2049/1/3ff/1", lead, nb, d0, df); end
        c0 = chi_starts; busy = 1'b0;
        ber_done = 1'b1; step(); ber_done = 1'b0;
        repeat (4) begin busy = busy | finish | ready | syn_start | ber_start; step(); end
        tests_run++; if (busy !== 1'b0 || chi_starts != c0) begin fails++; $display("FAIL tmo_late_done busy=%b chi_starts=%0d exp 0/%0d", busy, chi_starts, c0); end
    endtask

    task automatic test_robust();
        int beats, first, last, lat, lead, nb; logic ok, df, cs; logic [9:0] d0, d1;
        do_load(2'd1, 1'b0, 1'b1, beats, first, last, ok);
        tests_run++; if (beats != 8 || last != 7 || !ok) begin fails++; $display("FAIL rob_set_held beats=%0d last=%0d seq=%b exp 8/7/1", beats, last, ok); end
        tests_run++; if (syn_start !== 1'b1) begin fails++; $display("FAIL rob_syn_start got=%b exp=1", syn_start); end
        step(); step(); rst = 1'b1; step(); rst = 1'b0;
        tests_run++; if ({ready, load_we, syn_start, ber_start, chi_start, finish, dec_fail, cand_sel} !== 8'd0 || odata !== 10'd0 || load_addr !== 10'd0) begin fails++; $display("FAIL rob_rst flags=%b odata=%h load_addr=%0d exp 0/0/0", {ready, load_we, syn_start, ber_start, chi_start, finish, dec_fail, cand_sel}, odata, load_addr); end
        locbuf[0][0] = 10'd9;
        do_load(2'd1, 1'b0, 1'b0, beats, first, last, ok);
        stage(0, 2, 1'b0, 4'd0, lat); stage(1, 2, 1'b0, 4'd0, lat); stage(2, 2, 1'b0, 4'd1, lat);
        collect(50, lead, nb, d0, d1, df, cs);
        tests_run++; if (beats != 8 || nb != 1 || d0 !== 10'd9) begin fails++; $display("FAIL rob_restart beats=%0d out_beats=%0d d0=%0d exp 8/1/9", beats, nb, d0); end
    endtask

    initial begin
        for (int b = 0; b < 2; b++) for (int i = 0; i < 16; i++) locbuf[b][i] = 10'(100 * b + i);
        test_reset();
        test_hard63();
        test_back_to_back();
        test_code0_zero();
        test_soft();
        test_ber_fail();
        test_timeout();
        test_robust();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
